// File: rtl/writeback_stage.sv
// Writeback stage of the RV32IM pipeline: MEM/WB register, load extraction,
// register-file write-port drive and retired-instruction counter.
module writeback_stage #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_stall,
  input  logic                 wb_flush,
  input  logic                 mem_valid,
  input  logic [4:0]           mem_rd,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic [XLEN-1:0]      mem_load_data,
  input  logic [1:0]           mem_addr_lsb,
  input  logic [2:0]           mem_load_type,
  input  logic                 mem_wb_load,
  input  logic                 mem_wb_reg_file,
  output logic                 reg_file_wr_en,
  output logic [4:0]           reg_file_wr_addr,
  output logic [XLEN-1:0]      reg_file_wr_data,
  output logic                 misaligned_load,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  logic                 r_valid;
  logic [4:0]           r_rd;
  logic [XLEN-1:0]      r_alu_result;
  logic [XLEN-1:0]      r_load_data;
  logic [1:0]           r_addr_lsb;
  logic [2:0]           r_load_type;
  logic                 r_wb_load;
  logic                 r_wb_reg_file;
  logic [INSTRET_W-1:0] r_instret;

  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [XLEN-1:0]      w_load_value;
  logic                 w_is_half;
  logic                 w_is_word;
  logic                 w_misaligned;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_rd          <= '0;
      r_alu_result  <= '0;
      r_load_data   <= '0;
      r_addr_lsb    <= '0;
      r_load_type   <= '0;
      r_wb_load     <= 1'b0;
      r_wb_reg_file <= 1'b0;
    end else if (wb_flush) begin
      r_valid       <= 1'b0;
      r_rd          <= '0;
      r_alu_result  <= '0;
      r_load_data   <= '0;
      r_addr_lsb    <= '0;
      r_load_type   <= '0;
      r_wb_load     <= 1'b0;
      r_wb_reg_file <= 1'b0;
    end else if (!wb_stall) begin
      r_valid       <= mem_valid;
      r_rd          <= mem_rd;
      r_alu_result  <= mem_alu_result;
      r_load_data   <= mem_load_data;
      r_addr_lsb    <= mem_addr_lsb;
      r_load_type   <= mem_load_type;
      r_wb_load     <= mem_wb_load;
      r_wb_reg_file <= mem_wb_reg_file;
    end
  end

  // An instruction retires when it leaves WB, whether or not it wrote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (r_valid && !wb_stall) begin
      r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_byte       = r_load_data[7:0];
    w_half       = r_addr_lsb[1] ? r_load_data[31:16] : r_load_data[15:0];
    w_load_value = r_load_data;
    w_is_half    = 1'b0;
    w_is_word    = 1'b0;

    case (r_addr_lsb)
      2'd1:    w_byte = r_load_data[15:8];
      2'd2:    w_byte = r_load_data[23:16];
      2'd3:    w_byte = r_load_data[31:24];
      default: w_byte = r_load_data[7:0];
    endcase

    // Unlisted type codes behave as LW.
    case (r_load_type)
      LT_LB:   w_load_value = {{(XLEN-8){w_byte[7]}}, w_byte};
      LT_LBU:  w_load_value = {{(XLEN-8){1'b0}}, w_byte};
      LT_LH: begin
        w_load_value = {{(XLEN-16){w_half[15]}}, w_half};
        w_is_half    = 1'b1;
      end
      LT_LHU: begin
        w_load_value = {{(XLEN-16){1'b0}}, w_half};
        w_is_half    = 1'b1;
      end
      default: begin
        w_load_value = r_load_data;
        w_is_word    = 1'b1;
      end
    endcase

    w_misaligned = r_valid & r_wb_load &
                   ((w_is_half & r_addr_lsb[0]) | (w_is_word & (r_addr_lsb != 2'd0)));
  end

  assign misaligned_load  = w_misaligned;
  assign reg_file_wr_addr = r_rd;
  assign reg_file_wr_data = r_wb_load ? w_load_value : r_alu_result;
  assign reg_file_wr_en   = r_valid & r_wb_reg_file & (r_rd != 5'd0) & ~w_misaligned;
  assign instret          = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: reset, load-extraction table,
// stall/flush/wrap sequences and randomized traffic against a reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stall, wb_flush, mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result, mem_load_data;
  logic [1:0]  mem_addr_lsb;
  logic [2:0]  mem_load_type;
  logic        mem_wb_load, mem_wb_reg_file;
  logic        reg_file_wr_en;
  logic [4:0]  reg_file_wr_addr;
  logic [31:0] reg_file_wr_data;
  logic        misaligned_load;
  logic [63:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_stall         (wb_stall),
    .wb_flush         (wb_flush),
    .mem_valid        (mem_valid),
    .mem_rd           (mem_rd),
    .mem_alu_result   (mem_alu_result),
    .mem_load_data    (mem_load_data),
    .mem_addr_lsb     (mem_addr_lsb),
    .mem_load_type    (mem_load_type),
    .mem_wb_load      (mem_wb_load),
    .mem_wb_reg_file  (mem_wb_reg_file),
    .reg_file_wr_en   (reg_file_wr_en),
    .reg_file_wr_addr (reg_file_wr_addr),
    .reg_file_wr_data (reg_file_wr_data),
    .misaligned_load  (misaligned_load),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in WB plus the count.
  typedef struct {
    bit          valid;
    int unsigned rd;
    int unsigned alu;
    int unsigned word;
    int unsigned lsb;
    int unsigned typ;
    bit          load;
    bit          regf;
  } slot_t;

  slot_t           m_slot;
  longint unsigned m_instret;

  typedef struct {
    logic [2:0]  typ;
    logic [1:0]  lsb;
    logic [31:0] word;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  function automatic int unsigned access_size(int unsigned typ);
    if (typ == 0 || typ == 4) return 1;
    if (typ == 1 || typ == 5) return 2;
    return 4;
  endfunction

  function automatic int unsigned model_extract(int unsigned word, int unsigned lsb, int unsigned typ);
    int unsigned b = (word >> (8 * lsb)) % 256;
    int unsigned h = (word >> (16 * (lsb / 2))) % 65536;
    case (typ)
      0: return (b >= 128) ? b - 256 : b;
      4: return b;
      1: return (h >= 32768) ? h - 65536 : h;
      5: return h;
      default: return word;
    endcase
  endfunction

  function automatic bit model_mis();
    return m_slot.valid && m_slot.load && ((m_slot.lsb % access_size(m_slot.typ)) != 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot    = '{default: 0};
    m_instret = 0;
  endtask

  task automatic model_edge();
    if (m_slot.valid && !wb_stall) m_instret++;
    if (wb_flush) m_slot = '{default: 0};
    else if (!wb_stall) begin
      m_slot.valid = mem_valid;
      m_slot.rd    = mem_rd;
      m_slot.alu   = mem_alu_result;
      m_slot.word  = mem_load_data;
      m_slot.lsb   = mem_addr_lsb;
      m_slot.typ   = mem_load_type;
      m_slot.load  = mem_wb_load;
      m_slot.regf  = mem_wb_reg_file;
    end
  endtask

  task automatic compare_all(input string tag);
    bit          mis  = model_mis();
    bit          en   = m_slot.valid && m_slot.regf && m_slot.rd != 0 && !mis;
    int unsigned data = m_slot.load ? model_extract(m_slot.word, m_slot.lsb, m_slot.typ) : m_slot.alu;
    check({tag, ".wr_en"},   64'(reg_file_wr_en),   64'(en));
    check({tag, ".wr_addr"}, 64'(reg_file_wr_addr), 64'(m_slot.rd));
    check({tag, ".wr_data"}, 64'(reg_file_wr_data), 64'(data));
    check({tag, ".mis"},     64'(misaligned_load),  64'(mis));
    check({tag, ".instret"}, instret,               m_instret);
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] word, input logic [1:0] lsb, input logic [2:0] typ,
                         input logic ld, input logic regf);
    mem_valid = v; mem_rd = rd; mem_alu_result = alu; mem_load_data = word;
    mem_addr_lsb = lsb; mem_load_type = typ; mem_wb_load = ld; mem_wb_reg_file = regf;
  endtask

  task automatic set_bubble();
    set_mem(1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t        vecs[11];
    longint unsigned base;

    vecs[0]  = '{3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{3'b100, 2'd3, 32'h80FF7F01, 32'h00000080, 1'b0};
    vecs[2]  = '{3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF, 1'b0};
    vecs[3]  = '{3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01, 1'b0};
    vecs[4]  = '{3'b010, 2'd0, 32'h80FF7F01, 32'h80FF7F01, 1'b0};
    vecs[5]  = '{3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F, 1'b0};
    vecs[6]  = '{3'b010, 2'd1, 32'h80FF7F01, 32'h80FF7F01, 1'b1};
    vecs[7]  = '{3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF, 1'b1};
    vecs[8]  = '{3'b101, 2'd1, 32'h80FF7F01, 32'h00007F01, 1'b1};
    vecs[9]  = '{3'b011, 2'd0, 32'h80FF7F01, 32'h80FF7F01, 1'b0};
    vecs[10] = '{3'b111, 2'd2, 32'h80FF7F01, 32'h80FF7F01, 1'b1};

    rst = 1'b1; wb_stall = 1'b0; wb_flush = 1'b0;
    set_bubble();
    model_reset();
    #1;
    compare_all("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ALU op: visible one cycle later, counted when it departs.
    set_mem(1'b1, 5'd5, 32'h1234, 32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    cycle("alu");
    check("alu.wr_en",   64'(reg_file_wr_en),   64'd1);
    check("alu.wr_data", 64'(reg_file_wr_data), 64'h1234);
    set_bubble();
    cycle("alu_depart");
    check("alu.instret", instret, 64'd1);

    // Load extraction and misalignment table.
    foreach (vecs[i]) begin
      set_mem(1'b1, 5'(i + 10), $urandom, vecs[i].word, vecs[i].lsb, vecs[i].typ, 1'b1, 1'b1);
      cycle($sformatf("vec%0d", i));
      check($sformatf("vec%0d.data", i),  64'(reg_file_wr_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d.mis", i),   64'(misaligned_load),  64'(vecs[i].exp_mis));
      check($sformatf("vec%0d.wr_en", i), 64'(reg_file_wr_en),   64'(!vecs[i].exp_mis));
    end

    // Writes to x0 and stores are suppressed but still retire.
    set_mem(1'b1, 5'd0, 32'hDEAD, 32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    cycle("x0");
    check("x0.wr_en", 64'(reg_file_wr_en), 64'd0);
    set_mem(1'b1, 5'd9, 32'hBEEF, 32'h0, 2'd0, 3'd2, 1'b0, 1'b0);
    cycle("store");
    check("store.wr_en", 64'(reg_file_wr_en), 64'd0);
    base = m_instret;
    set_bubble();
    cycle("store_depart");
    check("store.instret", instret, base + 1);

    // Three-cycle stall holding addi x7.
    set_mem(1'b1, 5'd7, 32'h77, 32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    cycle("addi7");
    base = m_instret;
    wb_stall = 1'b1;
    set_mem(1'b1, 5'd8, 32'h88, 32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("stall%0d", k));
      check($sformatf("stall%0d.wr_en", k), 64'(reg_file_wr_en),   64'd1);
      check($sformatf("stall%0d.addr", k),  64'(reg_file_wr_addr), 64'd7);
      check($sformatf("stall%0d.cnt", k),   instret,               base);
    end
    wb_stall = 1'b0;
    cycle("stall_release");
    check("stall_release.cnt",  instret,                base + 1);
    check("stall_release.addr", 64'(reg_file_wr_addr), 64'd8);

    // Flush and stall together: bubble, no count.
    base = m_instret;
    wb_flush = 1'b1; wb_stall = 1'b1;
    cycle("flush_stall");
    check("flush_stall.wr_en", 64'(reg_file_wr_en), 64'd0);
    check("flush_stall.cnt",   instret,              base);
    wb_flush = 1'b0; wb_stall = 1'b0;

    // Flush without stall still counts the departing instruction.
    set_mem(1'b1, 5'd3, 32'h33, 32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    cycle("pre_flush");
    base = m_instret;
    wb_flush = 1'b1;
    cycle("flush");
    check("flush.cnt", instret, base + 1);
    wb_flush = 1'b0;

    // Counter wrap.
    set_mem(1'b1, 5'd4, 32'h44, 32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    cycle("pre_wrap");
    force dut.r_instret = '1;
    #1;
    release dut.r_instret;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("wrap.preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    set_bubble();
    cycle("wrap");
    check("wrap.cnt", instret, 64'd0);

    // Asynchronous reset while a stalled addi x5 is held.
    set_mem(1'b1, 5'd5, 32'h55, 32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    cycle("pre_rst");
    wb_stall = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst.wr_en",   64'(reg_file_wr_en),   64'd0);
    check("async_rst.addr",    64'(reg_file_wr_addr), 64'd0);
    check("async_rst.data",    64'(reg_file_wr_data), 64'd0);
    check("async_rst.instret", instret,               64'd0);
    #1;
    rst = 1'b0;
    set_bubble();
    cycle("post_rst");
    check("post_rst.wr_en", 64'(reg_file_wr_en), 64'd0);
    wb_stall = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wb_stall = ($urandom_range(0, 3) == 0);
      wb_flush = ($urandom_range(0, 9) == 0);
      set_mem(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, $urandom,
              2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      cycle("rand");
    end
    wb_stall = 1'b0; wb_flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32IM 5-stage core; drives the register-file write port (reg_file_wr_en/addr/data) consumed by the decode stage.
- Holds the MEM/WB pipeline register and extracts/extends load data per mem_load_type.
- Selects ALU result vs load data, suppresses illegal and x0 writes, and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_stall  in  1  hold the MEM/WB register contents.
- wb_flush  in  1  load a bubble into the MEM/WB register.
- mem_valid  in  1  MEM-stage slot holds a real instruction (0 = bubble).
- mem_rd  in  5  destination register.
- mem_alu_result  in  32  ALU / address / link result.
- mem_load_data  in  32  raw aligned word read from data memory.
- mem_addr_lsb  in  2  byte offset of the load address (addr[1:0]).
- mem_load_type  in  3  load kind, func3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_wb_load  in  1  result comes from memory.
- mem_wb_reg_file  in  1  instruction writes rd.
- reg_file_wr_en  out  1  register-file write enable.
- reg_file_wr_addr  out  5  register-file write address.
- reg_file_wr_data  out  32  register-file write data (also the WB forwarding source).
- misaligned_load  out  1  WB slot holds a misaligned load; its write is suppressed.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (async, rst=1): all MEM/WB fields are 0 (valid_q=0), instret=0. This forces reg_file_wr_en=0, reg_file_wr_addr=0, reg_file_wr_data=0 and misaligned_load=0. A reset mid-stall or mid-operation discards the held instruction immediately.
- Pipeline register update on each rising clk:
  - wb_flush=1: load a bubble (valid_q=0, other fields 0). Flush has priority over stall.
  - else wb_stall=1: hold all fields.
  - else: capture all mem_* inputs.
- Latency: an instruction presented on mem_* appears on the write port 1 cycle later. All outputs are combinational from registered state only; there is no input-to-output path.
- Load extraction from the byte/halfword selected by addr_lsb_q:
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - Halfword select: lsb[1]=0 -> bits [15:0], lsb[1]=1 -> bits [31:16].
  - Unlisted load_type codes (011, 110, 111) are treated as LW.
- Misalignment: misaligned_load = valid_q & wb_load_q & ((LH or LHU) & lsb[0], or (LW or unlisted type) & lsb!=0).
- Write data: reg_file_wr_data = wb_load_q ? extracted : alu_result_q. It is driven regardless of enable.
- reg_file_wr_addr = rd_q.
- Write enable: reg_file_wr_en = valid_q & wb_reg_file_q & (rd_q != 0) & ~misaligned_load.
- Stall: the write is repeated on every stalled cycle with identical addr/data. This is idempotent and is the required behaviour.
- instret increments by 1 on any rising edge where valid_q=1 & wb_stall=0 & rst=0, i.e. when the WB instruction departs.
  - Counted even if its write was suppressed (x0, stores, branches, misaligned).
  - Flush with wb_stall=0 still counts the departing instruction.
  - Wraps modulo 2^INSTRET_W with no saturation.
- Simultaneous flush and stall with valid_q=1: the register is bubbled. The instruction is not counted (stall=1), and it does not write on the next cycle.

Test Plan:
- rst=1 mid-run while holding `addi x5` -> all outputs 0 immediately (async); instret=0; x5 is not written after rst deasserts.
- ALU op (valid=1, rd=5, alu_result=0x1234, wb_load=0, wb_reg_file=1) -> next cycle wr_en=1, addr=5, data=0x00001234; instret +1 after the following edge.
- Load word 0x80FF7F01:
  - LB lsb=2 -> data=0xFFFFFFFF.
  - LBU lsb=3 -> data=0x00000080.
  - LH lsb=2 -> data=0xFFFF80FF.
  - LHU lsb=0 -> data=0x00007F01.
  - LW lsb=0 -> data=0x80FF7F01.
- Misaligned cases: LW lsb=1 or LH lsb=3 -> misaligned_load=1, wr_en=0; instret still increments on departure.
- rd=0 with wb_reg_file=1 -> wr_en=0 and instret increments. Store (wb_reg_file=0) -> wr_en=0 and instret increments.
- Stall and flush sequencing:
  - Stall 3 cycles with a valid `addi x7` in WB -> wr_en=1, addr=7 held for all 3 cycles; instret unchanged until stall drops, then +1 exactly once.
  - flush+stall together -> bubble loaded, no count.
  - instret preloaded via force to 2^64-1 -> wraps to 0 on the next retirement.
